// File: rtl/i2s_tx.sv
// i2s_tx: I2S transmitter with a one-sample holding register, a 2*DATA_W-bit shift register
// and one-bit-delayed framing.
module i2s_tx #(
   parameter int DATA_W  = 16,
   parameter int CLK_DIV = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] audio_l,
   input  logic [DATA_W-1:0] audio_r,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              bclk,
   output logic              lrclk,
   output logic              sdata,
   output logic              underrun
);
   localparam int FW = 2 * DATA_W;
   localparam int BW = $clog2(FW);
   localparam int DW = $clog2(CLK_DIV);
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(FW - 1);
   localparam logic [BW-1:0] HALF     = BW'(DATA_W);

   logic [DW-1:0] div_cnt_q, div_cnt_d;
   logic [BW-1:0] bit_cnt_q, bit_cnt_d;
   logic [FW-1:0] shift_q, shift_d, hold_q, hold_d;
   logic          full_q, full_d;
   logic          bclk_q, bclk_d, lrclk_q, lrclk_d, sdata_q, sdata_d, underrun_q, underrun_d;
   logic          tick, fall, load, xfer;

   // in_ready is held low combinationally while rst is high so no word is accepted in reset
   assign in_ready = ~full_q & ~rst;
   assign bclk     = bclk_q;
   assign lrclk    = lrclk_q;
   assign sdata    = sdata_q;
   assign underrun = underrun_q;

   always_comb begin
      tick       = div_cnt_q == DIV_LAST;
      fall       = tick & bclk_q;
      load       = fall & (bit_cnt_q == '0);
      xfer       = in_valid & in_ready;
      div_cnt_d  = tick ? '0 : div_cnt_q + 1'b1;
      bclk_d     = bclk_q ^ tick;
      bit_cnt_d  = fall ? (bit_cnt_q == BIT_LAST ? '0 : bit_cnt_q + 1'b1) : bit_cnt_q;
      shift_d    = load ? (full_q ? hold_q : '0) : fall ? shift_q << 1 : shift_q;
      sdata_d    = fall ? shift_d[FW-1] : sdata_q;
      lrclk_d    = fall ? bit_cnt_d >= HALF : lrclk_q;
      hold_d     = xfer ? {audio_l, audio_r} : hold_q;
      // a transfer coinciding with a load edge only lands after the load has seen empty
      full_d     = xfer | (full_q & ~load);
      underrun_d = load & ~full_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt_q  <= '0;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         hold_q     <= '0;
         full_q     <= 1'b0;
         bclk_q     <= 1'b0;
         lrclk_q    <= 1'b0;
         sdata_q    <= 1'b0;
         underrun_q <= 1'b0;
      end else begin
         div_cnt_q  <= div_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         hold_q     <= hold_d;
         full_q     <= full_d;
         bclk_q     <= bclk_d;
         lrclk_q    <= lrclk_d;
         sdata_q    <= sdata_d;
         underrun_q <= underrun_d;
      end
   end
endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: randomized bench for i2s_tx against a frame-timing reference model.
module tb_i2s_tx;
   logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0;
   logic [15:0] audio_l = '0, audio_r = '0;
   logic        in_ready, bclk, lrclk, sdata, underrun;
   int          checks = 0, fails = 0, n = 0, ur_cnt = 0;
   bit          m_full;
   bit   [31:0] m_hold;
   bit   [31:0] frm [0:79];
   bit   [31:0] txq [$];
   bit          cap [0:40];
   logic [15:0] lw, rw;

   always #5 clk = ~clk;

   i2s_tx #(.DATA_W(16), .CLK_DIV(4)) dut (
      .clk(clk), .rst(rst), .audio_l(audio_l), .audio_r(audio_r), .in_valid(in_valid),
      .in_ready(in_ready), .bclk(bclk), .lrclk(lrclk), .sdata(sdata), .underrun(underrun)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, n);
      end
   endtask

   task automatic do_reset(input int cyc);
      rst = 1'b1;
      in_valid = 1'b0;
      repeat (cyc) begin
         @(posedge clk);
         #1;
         check("rst_bclk", bclk, 0);
         check("rst_lrclk", lrclk, 0);
         check("rst_sdata", sdata, 0);
         check("rst_underrun", underrun, 0);
         check("rst_in_ready", in_ready, 0);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("ready_after_rst", in_ready, 1);
      n = 0;
      m_full = 1'b0;
      ur_cnt = 0;
      foreach (cap[i]) cap[i] = 1'b0;
   endtask

   // Reference: falling BCLK edge k happens at clk edge 8k; frame f is loaded at edge 256f+8
   // and bit p of it (MSB first) is on sdata from falling edge 32f+1+p.
   task automatic run(input int cyc, input int start_at, input bit rnd);
      for (int i = 0; i < cyc; i++) begin
         bit ld, xf, exp_ur;
         int k;
         in_valid = txq.size() > 0 && n + 1 >= start_at && (!rnd || $urandom_range(2) == 0);
         {audio_l, audio_r} = in_valid ? txq[0] : $urandom;
         @(posedge clk);
         n++;
         xf = in_valid && !m_full;
         ld = (n % 256) == 8;
         exp_ur = ld && !m_full;
         if (ld) begin
            frm[n / 256] = m_full ? m_hold : 32'h0;
            m_full = 1'b0;
         end
         if (xf) begin
            m_hold = txq.pop_front();
            m_full = 1'b1;
         end
         #1;
         k = n / 8;
         check("bclk", bclk, (n / 4) % 2);
         check("lrclk", lrclk, (k % 32) >= 16);
         check("sdata", sdata, k == 0 ? 0 : frm[(k - 1) / 32][31 - (k - 1) % 32]);
         check("underrun", underrun, exp_ur);
         check("in_ready", in_ready, !m_full);
         if (underrun) ur_cnt++;
         if (n % 8 == 0 && k <= 40) cap[k] = sdata;
      end
   endtask

   initial begin
      do_reset(3);
      txq.push_back({16'hA5F0, 16'h0F0F});
      run(270, 1, 1'b0);
      for (int j = 0; j < 16; j++) begin
         lw[15 - j] = cap[1 + j];
         rw[15 - j] = cap[17 + j];
      end
      check("left_slot", lw, 16'hA5F0);
      check("right_slot", rw, 16'h0F0F);

      do_reset(2);
      for (int j = 0; j < 64; j++) txq.push_back($urandom);
      run(16391, 1, 1'b0);
      check("stream_underruns", ur_cnt, 0);
      check("stream_drained", txq.size(), 0);

      do_reset(2);
      run(1024, 1, 1'b0);
      check("idle_underruns", ur_cnt, 4);

      do_reset(2);
      txq.push_back($urandom);
      run(519, 8, 1'b0);
      check("edge_underruns", ur_cnt, 1);

      do_reset(2);
      txq.push_back({16'hFFFF, 16'($urandom)});
      run(80, 1, 1'b0);
      do_reset(1);
      run(263, 1, 1'b0);
      check("post_rst_underruns", ur_cnt, 1);

      do_reset(2);
      for (int j = 0; j < 20; j++) txq.push_back($urandom);
      run(1536, 1, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule

// File: doc/i2s_tx.md
I2S_TX -- requirements
Module: i2s_tx

Interface
REQ-001 Parameter DATA_W, default 16, the sample width per channel.
REQ-002 Parameter CLK_DIV, default 4, the number of clk cycles per BCLK half-period; legal values are 2 or more.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 clk  input  1  system clock; all logic is clocked on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 audio_l  input  DATA_W  left-channel sample, two's complement.
REQ-007 audio_r  input  DATA_W  right-channel sample, two's complement.
REQ-008 in_valid  input  1  the sample pair is valid.
REQ-009 in_ready  output  1  the holding register is empty.
REQ-010 bclk  output  1  serial bit clock.
REQ-011 lrclk  output  1  word select: 0 = left channel, 1 = right channel.
REQ-012 sdata  output  1  serial data, MSB first.
REQ-013 underrun  output  1  one-cycle pulse when a frame is loaded with no sample available.

Function
REQ-014 Divider: div_cnt counts 0 to CLK_DIV-1 and wraps; bclk SHALL toggle in the cycle where div_cnt = CLK_DIV-1, giving a BCLK period of 2*CLK_DIV clk cycles.
REQ-015 Falling BCLK edge: the clk cycle in which bclk goes from 1 to 0; all changes to lrclk, sdata and the bit counter SHALL occur only in such cycles.
REQ-016 Bit counter: bit_cnt is 5 bits, counts 0 to 31, increments on each falling BCLK edge and wraps from 31 to 0; one frame is 32 BCLK periods.
REQ-017 lrclk SHALL be 0 while bit_cnt is 0..15 and 1 while bit_cnt is 16..31.
REQ-018 I2S one-bit delay:
- bit_cnt 1..16: sdata carries L[15..0].
- bit_cnt 17..31, then the next 0: sdata carries R[15..0].
REQ-019 Load edge: the falling edge where bit_cnt becomes 1. In that cycle a 2*DATA_W shift register SHALL load {L,R} from the holding register, and sdata SHALL output L[15] in the same cycle.
REQ-020 On every other falling edge, the shift register SHALL shift left by 1 and sdata SHALL take the new MSB.
REQ-021 Handshake: a transfer occurs when in_valid && in_ready; the holding register captures {audio_l, audio_r} and becomes full.
- in_ready = !full.
- The input data may change freely when there is no transfer.
REQ-022 If the holding register is full at a load edge, it SHALL be emptied in that cycle, so in_ready = 1 in the next cycle.
REQ-023 If the holding register is empty at a load edge:
- The shift register loads all zeros.
- underrun = 1 for exactly that cycle.
REQ-024 Simultaneous load edge and transfer (holding register empty): the load edge sees empty, so REQ-023 applies, and the new word is held for the next frame.
REQ-025 Latency: a word accepted at least 1 clk before a load edge SHALL appear on sdata starting at that load edge.
REQ-026 Width: samples pass through unmodified, with no rounding and no sign extension.

Reset
REQ-027 While rst = 1, the following SHALL hold at the next rising clk edge:
- bclk = 0, lrclk = 0, sdata = 0, underrun = 0, in_ready = 0.
- div_cnt = 0, bit_cnt = 0, shift register = 0, holding register empty.
REQ-028 In the first cycle after rst deasserts, in_ready SHALL be 1; the first falling BCLK edge SHALL occur 2*CLK_DIV cycles after rst deasserts, and bit_cnt becomes 1 there (a load edge).
REQ-029 A reset asserted mid-frame SHALL abort the frame and discard the holding register contents; nothing partial is transmitted after reset.

Verification
REQ-030 Reset, CLK_DIV=4: assert rst for 3 cycles -> all outputs 0 during reset; in_ready = 1 in the first cycle after; first bclk rise 4 cycles after rst deasserts.
REQ-031 Single pair L=16'hA5F0, R=16'h0F0F, presented before the first load edge:
- Left slot (bit_cnt 1..16): sdata = 1010010111110000 with lrclk low, except lrclk high on the left LSB.
- Right slot: 0000111100001111, with the right LSB sent at bit_cnt 0 of the next frame and lrclk low there.
REQ-032 Stream 64 sine-table words, driving in_valid whenever in_ready:
- No underrun pulse.
- in_ready low from accept until the next load edge.
- Deserialized output equals the input sequence.
REQ-033 Idle (in_valid = 0 throughout) -> sdata stays 0; underrun pulses once per 256 clk cycles, at each load edge.
REQ-034 in_valid first asserted exactly in a load-edge cycle with the holding register empty -> underrun pulses and a zero frame is sent; the word is sent in the following frame.
REQ-035 rst asserted at bit_cnt = 10 of a frame carrying L=16'hFFFF -> outputs 0 and in_ready = 0 the next cycle; after release, the first frame is an underrun frame (zeros) unless a new word is supplied.
